// File: rtl/auction_seq_if.sv
// Bid stream and result bus of the sequential auction engine.
// The master side starts auctions and supplies bids; the slave side is the engine.
interface auction_seq_if #(
    parameter int N = 2,
    parameter int W = 16
);
    logic         start;
    logic         mode;
    logic         bid_valid;
    logic         bid_ready;
    logic [W-1:0] bid;
    logic         busy;
    logic         done;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic [W-1:0] price;

    modport master (
        output start, mode, bid_valid, bid,
        input  bid_ready, busy, done, winner, winning_bid, price
    );

    modport slave (
        input  start, mode, bid_valid, bid,
        output bid_ready, busy, done, winner, winning_bid, price
    );
endinterface

// File: rtl/auction_seq.sv
// Streaming sealed-bid auction: collects 2**N bids and tracks best, second and winner.
// Reports the clearing price as first-price (best) or Vickrey (second) per the latched mode.
//
//  state   | meaning
//  IDLE    | after reset, waiting for start
//  COLLECT | accepting one bid per cycle until 2**N have arrived
//  DONE    | result valid; done pulses in the first cycle; start relaunches
module auction_seq #(
    parameter int N = 2,
    parameter int W = 16
) (
    input logic        clk,
    input logic        rst,
    auction_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [N:0] LAST_IDX = (N+1)'((2 ** N) - 1);

    state_t       state, state_nx;
    logic         launch, accept, last_bid;
    logic [W-1:0] best, second, best_nx, second_nx;
    logic [N-1:0] win_idx, win_idx_nx;
    logic [N:0]   idx;
    logic         mode_q, done_q;
    logic [N-1:0] winner_q;
    logic [W-1:0] winning_bid_q, price_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        launch        = 1'b0;
        accept        = 1'b0;
        last_bid      = 1'b0;
        bus.bid_ready = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    launch   = 1'b1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                bus.bid_ready = 1'b1;
                bus.busy      = 1'b1;
                accept        = bus.bid_valid;
                if (accept && (idx == LAST_IDX)) begin
                    last_bid = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strict greater-than keeps the earlier bidder on a tie and pushes the tie into second.
    always_comb begin
        best_nx    = best;
        second_nx  = second;
        win_idx_nx = win_idx;
        if (bus.bid > best) begin
            second_nx  = best;
            best_nx    = bus.bid;
            win_idx_nx = idx[N-1:0];
        end else if (bus.bid > second) begin
            second_nx = bus.bid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best          <= '0;
            second        <= '0;
            win_idx       <= '0;
            idx           <= '0;
            mode_q        <= 1'b0;
            done_q        <= 1'b0;
            winner_q      <= '0;
            winning_bid_q <= '0;
            price_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                best    <= '0;
                second  <= '0;
                win_idx <= '0;
                idx     <= '0;
                mode_q  <= bus.mode;
            end else if (accept) begin
                best    <= best_nx;
                second  <= second_nx;
                win_idx <= win_idx_nx;
                idx     <= idx + (N+1)'(1);
                // Result is taken from the post-update values so the last bid counts.
                if (last_bid) begin
                    winner_q      <= win_idx_nx;
                    winning_bid_q <= best_nx;
                    price_q       <= mode_q ? second_nx : best_nx;
                    done_q        <= 1'b1;
                end
            end
        end
    end

    assign bus.done        = done_q;
    assign bus.winner      = winner_q;
    assign bus.winning_bid = winning_bid_q;
    assign bus.price       = price_q;
endmodule
